// File: rtl/lfa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfa_pkg
// Purpose  : Shared types and constants for the line-follower ADC scan
//            scheduler: scan slot order, FSM state encoding, SPI frame
//            geometry and the frame-word builder.
// Revision : 1.0 - initial release
// ============================================================================
package lfa_pkg;

    localparam int c_FRAME_LEN = 16;  // sclk periods per SPI transfer
    localparam int c_RESULT_W  = 12;  // ADC result width

    typedef enum logic [1:0] {
        SLOT_L = 2'd0,
        SLOT_C = 2'd1,
        SLOT_R = 2'd2
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    function automatic slot_t slot_next(input slot_t s);
        case (s)
            SLOT_L:  return SLOT_C;
            SLOT_C:  return SLOT_R;
            default: return SLOT_L;
        endcase
    endfunction

    // Control word sent MSB first: two don't-care zeros, channel, zero pad.
    function automatic logic [c_FRAME_LEN-1:0] frame_word(input logic [2:0] addr);
        return {2'b00, addr, 11'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_spi_frame.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_frame
// Purpose  : One 16-bit SPI transfer to the ADC. On start (accepted only
//            while cs_n is high) drops cs_n for a CLK_DIV-cycle setup, then
//            runs 16 sclk periods. din advances on sclk falling edges, dout
//            is sampled on rising edges; the last 12 samples form result.
// Ports    : clk_50M, reset (async, active high), start, addr[2:0], dout
//            adc_sclk, adc_cs_n, din, shifting (sclk phase active),
//            done (high in the cycle before cs_n rises), result[11:0]
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_frame
    import lfa_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic                  clk_50M,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            addr,
    input  logic                  dout,
    output logic                  adc_sclk,
    output logic                  adc_cs_n,
    output logic                  din,
    output logic                  shifting,
    output logic                  done,
    output logic [c_RESULT_W-1:0] result
);

    localparam int                  c_DIV_W     = $clog2(CLK_DIV + 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_LOAD  = c_DIV_W'(CLK_DIV - 1);
    localparam int                  c_HALF_W    = $clog2(2 * c_FRAME_LEN);
    localparam logic [c_HALF_W-1:0] c_HALF_LAST = c_HALF_W'(2 * c_FRAME_LEN - 1);

    logic                   r_sclk;
    logic                   r_cs_n;
    logic                   r_shifting;
    logic [c_DIV_W-1:0]     r_div;
    logic [c_HALF_W-1:0]    r_half;     // index of the current sclk half period
    logic [c_FRAME_LEN-1:0] r_tx;
    logic [c_RESULT_W-1:0]  r_rx;       // older samples simply fall off the top

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_sclk     <= 1'b1;
            r_cs_n     <= 1'b1;
            r_shifting <= 1'b0;
            r_div      <= '0;
            r_half     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
        end else if (r_cs_n) begin
            if (start) begin
                r_cs_n     <= 1'b0;
                r_sclk     <= 1'b1;
                r_tx       <= frame_word(addr);   // bit15 valid at cs_n fall
                r_div      <= c_DIV_LOAD;
                r_half     <= '0;
                r_shifting <= 1'b0;
            end
        end else if (r_div != '0) begin
            r_div <= r_div - 1'b1;
        end else begin
            r_div <= c_DIV_LOAD;
            if (!r_shifting) begin
                // End of setup: first falling edge keeps bit15 on din.
                r_shifting <= 1'b1;
                r_sclk     <= 1'b0;
            end else begin
                r_half <= r_half + 1'b1;
                if (!r_half[0]) begin
                    r_sclk <= 1'b1;
                    r_rx   <= {r_rx[c_RESULT_W-2:0], dout};
                end else if (r_half == c_HALF_LAST) begin
                    r_cs_n     <= 1'b1;
                    r_shifting <= 1'b0;
                    r_half     <= '0;
                    r_tx       <= '0;
                end else begin
                    r_sclk <= 1'b0;
                    r_tx   <= {r_tx[c_FRAME_LEN-2:0], 1'b0};
                end
            end
        end
    end

    assign adc_sclk = r_sclk;
    assign adc_cs_n = r_cs_n;
    assign din      = r_tx[c_FRAME_LEN-1];
    assign shifting = r_shifting;
    assign done     = r_shifting && (r_div == '0) && (r_half == c_HALF_LAST);
    assign result   = r_rx;

endmodule
`default_nettype wire

// File: rtl/lfa_scan_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lfa_scan_scheduler
// Purpose  : Enable-gated L/C/R scan of the line-follower ADC. Addresses the
//            channels in L,C,R order, discards the priming frame after idle,
//            collects the pipelined results in shadows and publishes all
//            three together with a one-cycle frame_valid strobe.
// Ports    : clk_50M, reset (async, active high), enable, dout
//            adc_sclk, adc_cs_n, din, left_value/center_value/right_value[11:0],
//            frame_valid, busy
// Options  : LFA_AVG_EN - average 2^AVG_LOG2 scans per publish
// Revision : 1.0 - initial release
// ============================================================================
module lfa_scan_scheduler
    import lfa_pkg::*;
#(
    parameter int         CLK_DIV   = 25,
    parameter int         GAP_CYC   = 50,
    parameter logic [2:0] CH_LEFT   = 3'd3,
    parameter logic [2:0] CH_CENTER = 3'd4,
    parameter logic [2:0] CH_RIGHT  = 3'd5,
    parameter int         AVG_LOG2  = 2
) (
    input  logic                  clk_50M,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  dout,
    output logic                  adc_sclk,
    output logic                  adc_cs_n,
    output logic                  din,
    output logic [c_RESULT_W-1:0] left_value,
    output logic [c_RESULT_W-1:0] center_value,
    output logic [c_RESULT_W-1:0] right_value,
    output logic                  frame_valid,
    output logic                  busy
);

    localparam int                 c_GAP_W    = $clog2(GAP_CYC + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYC - 1);

    if ((CLK_DIV < 2) || (CLK_DIV > 255) || (GAP_CYC < 1) || (AVG_LOG2 < 0)) begin : g_param_check
        $error("lfa_scan_scheduler: illegal parameter value");
    end

    state_t                r_state;
    slot_t                 r_slot;      // slot addressed by the current/next frame
    logic                  r_prime;     // current frame's result is stale
    logic [c_GAP_W-1:0]    r_gap;
    logic [c_RESULT_W-1:0] r_sh_l;
    logic [c_RESULT_W-1:0] r_sh_c;
    logic [c_RESULT_W-1:0] r_left;
    logic [c_RESULT_W-1:0] r_center;
    logic [c_RESULT_W-1:0] r_right;
    logic                  r_valid;
    logic                  r_busy;

    logic                  w_start;
    logic [2:0]            w_addr;
    logic                  w_shifting;
    logic                  w_done;
    logic [c_RESULT_W-1:0] w_result;

`ifdef LFA_AVG_EN
    localparam int                  c_ACC_W     = c_RESULT_W + AVG_LOG2;
    localparam logic [AVG_LOG2:0]   c_SCAN_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    logic [c_ACC_W-1:0] r_acc_l;
    logic [c_ACC_W-1:0] r_acc_c;
    logic [c_ACC_W-1:0] r_acc_r;
    logic [AVG_LOG2:0]  r_scan_cnt;
    logic [c_ACC_W-1:0] w_sum_l;
    logic [c_ACC_W-1:0] w_sum_c;
    logic [c_ACC_W-1:0] w_sum_r;

    assign w_sum_l = r_acc_l + c_ACC_W'(r_sh_l);
    assign w_sum_c = r_acc_c + c_ACC_W'(r_sh_c);
    assign w_sum_r = r_acc_r + c_ACC_W'(w_result);
`endif

    // A new frame starts straight out of IDLE or at the last GAP cycle.
    assign w_start = enable && ((r_state == ST_IDLE) ||
                                ((r_state == ST_GAP) && (r_gap == '0)));

    always_comb begin
        w_addr = CH_LEFT;
        if (r_state != ST_IDLE) begin
            case (r_slot)
                SLOT_C:  w_addr = CH_CENTER;
                SLOT_R:  w_addr = CH_RIGHT;
                default: w_addr = CH_LEFT;
            endcase
        end
    end

    adc_spi_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clk_50M  (clk_50M),
        .reset    (reset),
        .start    (w_start),
        .addr     (w_addr),
        .dout     (dout),
        .adc_sclk (adc_sclk),
        .adc_cs_n (adc_cs_n),
        .din      (din),
        .shifting (w_shifting),
        .done     (w_done),
        .result   (w_result)
    );

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_slot   <= SLOT_L;
            r_prime  <= 1'b1;
            r_gap    <= '0;
            r_sh_l   <= '0;
            r_sh_c   <= '0;
            r_left   <= '0;
            r_center <= '0;
            r_right  <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
`ifdef LFA_AVG_EN
            r_acc_l    <= '0;
            r_acc_c    <= '0;
            r_acc_r    <= '0;
            r_scan_cnt <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_SETUP;
                        r_busy  <= 1'b1;
                        r_slot  <= SLOT_L;
                        r_prime <= 1'b1;
`ifdef LFA_AVG_EN
                        r_acc_l    <= '0;
                        r_acc_c    <= '0;
                        r_acc_r    <= '0;
                        r_scan_cnt <= '0;
`endif
                    end
                end
                ST_SETUP: begin
                    if (w_shifting) r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_done) begin
                        r_state <= ST_GAP;
                        r_gap   <= c_GAP_LOAD;
                        r_prime <= 1'b0;
                        r_slot  <= slot_next(r_slot);
                        // The result belongs to the slot addressed one frame earlier.
                        if (!r_prime) begin
                            case (r_slot)
                                SLOT_C: r_sh_l <= w_result;
                                SLOT_R: r_sh_c <= w_result;
                                SLOT_L: begin
`ifdef LFA_AVG_EN
                                    if (r_scan_cnt == c_SCAN_LAST) begin
                                        r_left     <= w_sum_l[c_ACC_W-1:AVG_LOG2];
                                        r_center   <= w_sum_c[c_ACC_W-1:AVG_LOG2];
                                        r_right    <= w_sum_r[c_ACC_W-1:AVG_LOG2];
                                        r_valid    <= 1'b1;
                                        r_acc_l    <= '0;
                                        r_acc_c    <= '0;
                                        r_acc_r    <= '0;
                                        r_scan_cnt <= '0;
                                    end else begin
                                        r_acc_l    <= w_sum_l;
                                        r_acc_c    <= w_sum_c;
                                        r_acc_r    <= w_sum_r;
                                        r_scan_cnt <= r_scan_cnt + 1'b1;
                                    end
`else
                                    r_left   <= r_sh_l;
                                    r_center <= r_sh_c;
                                    r_right  <= w_result;
                                    r_valid  <= 1'b1;
`endif
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - 1'b1;
                    end else if (enable) begin
                        r_state <= ST_SETUP;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign left_value   = r_left;
    assign center_value = r_center;
    assign right_value  = r_right;
    assign frame_valid  = r_valid;
    assign busy         = r_busy;

endmodule
`default_nettype wire
